// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial BCD subtractor, LSD first, start/busy/done handshake
// Define BCD_SUB_MAGNITUDE_EN to add the FIX pass that turns negative results into sign-magnitude.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   Minuend,
   input  logic [4*DIGITS-1:0]   Subtrahend,
   input  logic                  Borrow_in,
   output logic [4*DIGITS-1:0]   Difference,
   output logic                  Borrow_out,
   output logic                  Invalid,
   output logic                  busy,
   output logic                  done
);

   localparam int IW = $clog2(DIGITS + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [IW-1:0] IDX_END  = IW'(DIGITS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SUB  = 2'd1;
`ifdef BCD_SUB_MAGNITUDE_EN
   localparam logic [1:0] S_FIX  = 2'd2;
`endif
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            r_state;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_a;
   logic [4*DIGITS-1:0]   r_b;
   logic [4*DIGITS-1:0]   r_diff;
   logic                  r_borrow;
   logic                  r_borrow_out;
   logic                  r_invalid;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_invalid;
   logic [3:0]            w_a;
   logic [3:0]            w_b;
`ifdef BCD_SUB_MAGNITUDE_EN
   logic [3:0]            w_r;
`endif
   logic [3:0]            w_op_a;
   logic [3:0]            w_op_b;
   logic [4:0]            w_d;
   logic [3:0]            w_dig;

   always_comb begin
      w_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (Minuend[4*i +: 4] > 4'd9 || Subtrahend[4*i +: 4] > 4'd9)
            w_invalid = 1'b1;
      end
   end

   // Digit selected by the running index; same subtract cell serves SUB and FIX.
   always_comb begin
      w_a = 4'd0;
      w_b = 4'd0;
`ifdef BCD_SUB_MAGNITUDE_EN
      w_r = 4'd0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_a = r_a[4*i +: 4];
            w_b = r_b[4*i +: 4];
`ifdef BCD_SUB_MAGNITUDE_EN
            w_r = r_diff[4*i +: 4];
`endif
         end
      end
      w_op_a = w_a;
      w_op_b = w_b;
`ifdef BCD_SUB_MAGNITUDE_EN
      if (r_state == S_FIX) begin
         w_op_a = 4'd0;
         w_op_b = w_r;
      end
`endif
      w_d   = {1'b0, w_op_a} - {1'b0, w_op_b} - {4'b0000, r_borrow};
      w_dig = w_d[4] ? (w_d[3:0] + 4'd10) : w_d[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_diff       <= '0;
         r_borrow     <= 1'b0;
         r_borrow_out <= 1'b0;
         r_invalid    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a          <= Minuend;
                  r_b          <= Subtrahend;
                  r_borrow     <= Borrow_in;
                  r_idx        <= '0;
                  r_diff       <= '0;
                  r_borrow_out <= 1'b0;
                  r_invalid    <= w_invalid;
                  r_busy       <= 1'b1;
                  r_state      <= S_SUB;
               end
            end
            S_SUB: begin
               if (r_idx == IDX_END) begin
                  // Extra cycle after the last digit publishes the sign.
                  r_borrow_out <= r_borrow;
`ifdef BCD_SUB_MAGNITUDE_EN
                  if (r_borrow) begin
                     r_idx    <= '0;
                     r_borrow <= 1'b0;
                     r_state  <= S_FIX;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
`else
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
`endif
               end else begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (r_idx == IW'(i))
                        r_diff[4*i +: 4] <= w_dig;
                  end
                  r_borrow <= w_d[4];
                  r_idx    <= r_idx + IW'(1);
               end
            end
`ifdef BCD_SUB_MAGNITUDE_EN
            S_FIX: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (r_idx == IW'(i))
                     r_diff[4*i +: 4] <= w_dig;
               end
               r_borrow <= w_d[4];
               if (r_idx == IDX_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
`endif
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Difference = r_diff;
   assign Borrow_out = r_borrow_out;
   assign Invalid    = r_invalid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
